// File: rtl/tcore_param.sv
// tcore_param: shared core widths, exception tags, prediction info and fetch-queue entry layout.
package tcore_param;
  localparam int XLEN = 32;
  localparam int FQ_DEPTH = 4;
  typedef enum logic [3:0] {
    NO_EXCEPTION          = 4'd0,
    INSTR_ADDR_MISALIGNED = 4'd1,
    INSTR_ACCESS_FAULT    = 4'd2,
    ILLEGAL_INSTR         = 4'd3,
    BREAKPOINT            = 4'd4,
    INSTR_PAGE_FAULT      = 4'd5
  } exc_type_e;
  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_info_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            is_comp;
    exc_type_e       exc;
    predict_info_t   spec;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch-to-decode instruction queue with exception hold and flush.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass fetch inputs straight to decode.
module fetch_queue
  import tcore_param::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fe_valid_i,
  output logic                       fe_ready_o,
  input  logic [XLEN-1:0]            fe_pc_i,
  input  logic [XLEN-1:0]            fe_inst_i,
  input  logic                       fe_is_comp_i,
  input  exc_type_e                  fe_exc_i,
  input  predict_info_t              fe_spec_i,
  output logic                       de_valid_o,
  input  logic                       de_ready_i,
  output logic [XLEN-1:0]            de_pc_o,
  output logic [XLEN-1:0]            de_inst_o,
  output logic                       de_is_comp_o,
  output exc_type_e                  de_exc_o,
  output predict_info_t              de_spec_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  fq_entry_t mem [DEPTH];
  fq_entry_t fe_entry, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic exc_hold, accept, bypass, enq, deq;
  assign fe_entry = '{pc: fe_pc_i, inst: fe_inst_i, is_comp: fe_is_comp_i, exc: fe_exc_i, spec: fe_spec_i};
  assign fe_ready_o = (count < CW'(DEPTH)) && !exc_hold && !flush_i;
  assign accept = fe_valid_i && fe_ready_o;
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = accept && (count == '0);
`else
  assign bypass = 1'b0;
`endif
  assign head = bypass ? fe_entry : mem[rd_ptr];
  assign de_valid_o = ((count != '0) || bypass) && !flush_i;
  assign deq = de_ready_i && (count != '0) && !flush_i;
  // a bypassed entry consumed in the same cycle never touches storage
  assign enq = accept && !(bypass && de_ready_i);
  assign de_pc_o = head.pc;
  assign de_inst_o = head.inst;
  assign de_is_comp_o = head.is_comp;
  assign de_exc_o = head.exc;
  assign de_spec_o = head.spec;
  assign count_o = count;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      exc_hold <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      exc_hold <= 1'b0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= fe_entry;
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
      if (accept && fe_exc_i != NO_EXCEPTION) exc_hold <= 1'b1;
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, >= 2.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 flush_i  input  1  discard all entries (mispredict/trap redirect).
REQ-005 fe_valid_i  input  1  fetch stage presents an instruction.
REQ-006 fe_ready_o  output  1  queue accepts the presented instruction.
REQ-007 fe_pc_i / fe_inst_i  input  XLEN each  instruction address / expanded 32-bit instruction.
REQ-008 fe_is_comp_i  input  1  original instruction was compressed.
REQ-009 fe_exc_i  input  exc_type_e  fetch-side exception tag.
REQ-010 fe_spec_i  input  predict_info_t  branch prediction for this instruction.
REQ-011 de_valid_o  output  1  head entry valid for decode.
REQ-012 de_ready_i  input  1  decode consumes head entry.
REQ-013 de_pc_o, de_inst_o, de_is_comp_o, de_exc_o, de_spec_o  output  same widths/types as fetch side  head entry fields.
REQ-014 count_o  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Enqueue occurs when fe_valid_i && fe_ready_o && !flush_i; dequeue when de_valid_o && de_ready_i.
REQ-016 fe_ready_o = (count_o < DEPTH) && !exc_hold && !flush_i; no combinational path from de_ready_i.
REQ-017 de_valid_o = (count_o != 0) && !flush_i.
REQ-018 Data outputs reflect the head entry directly from storage; values are don't-care while de_valid_o = 0.
REQ-019 Without bypass, enqueue-to-de_valid_o latency is exactly 1 cycle.
REQ-020 Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-021 Simultaneous enqueue and dequeue leave count_o unchanged; permitted at any non-full occupancy.
REQ-022 Full (count_o = DEPTH): fe_ready_o = 0; a dequeue that cycle frees one slot, visible the next cycle.
REQ-023 Empty: dequeue is impossible; count_o never underflows or exceeds DEPTH.
REQ-024 exc_hold state: set when an entry with fe_exc_i != NO_EXCEPTION is enqueued; while set, fe_ready_o = 0; cleared only by flush_i or reset.
REQ-025 Entries already queued ahead of and including the faulting entry drain normally while exc_hold is set.
REQ-026 flush_i: in the flush cycle, no enqueue or dequeue takes effect; next cycle count_o = 0, both pointers = 0, exc_hold = 0.
REQ-027 flush_i has priority over every simultaneous event, including full/empty and exc_hold.

Reset
REQ-028 On rst_i: count_o = 0, pointers = 0, exc_hold = 0, all storage entries zero, de_valid_o = 0, fe_ready_o = 1 once rst_i deasserts.
REQ-029 Reset asserted mid-operation discards all entries immediately, regardless of handshakes in progress.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN defined: when queue empty, fe_valid_i = 1, enqueue permitted, and !flush_i, de_valid_o = 1 same cycle with fetch inputs driven to outputs; if de_ready_i = 1 the entry is not written and count_o stays 0.
REQ-031 FETCH_QUEUE_BYPASS_EN undefined: no fetch-to-decode combinational path; REQ-019 latency applies.

Structure
REQ-032 fq_entry_t (pc, inst, is_comp, exc, spec) and FQ_DEPTH default belong in tcore_param; exc_type_e and predict_info_t are reused from it.
REQ-033 Storage is an inline array of fq_entry_t; no sub-module.

Verification
REQ-034 Fill: 4 enqueues (pc 0x8000_0000..0x8000_000C), de_ready_i = 0 -> count_o = 4, fe_ready_o = 0; then drain -> pcs out in order.
REQ-035 Wrap: 10 continuous enq+deq at count 2 -> count_o stays 2, outputs in order across pointer wrap.
REQ-036 Exception: enqueue pc 0x8000_0010 with INSTR_ACCESS_FAULT -> fe_ready_o = 0 next cycle; entry drains with de_exc_o = INSTR_ACCESS_FAULT; flush_i -> fe_ready_o = 1.
REQ-037 Flush with count 3 and concurrent fe_valid_i/de_ready_i -> nothing accepted or consumed; next cycle count_o = 0, de_valid_o = 0.
REQ-038 Async reset pulse mid-drain (count 2) -> de_valid_o = 0 immediately, count_o = 0 without clock edge.
REQ-039 Bypass build: empty queue, fe_valid_i = 1, de_ready_i = 1, pc 0x8000_0020 -> same-cycle de_valid_o = 1, de_pc_o = 0x8000_0020, count_o remains 0.
